cnn_stream_collector: RTL and testbench
=======================================

Name: cnn_stream_collector

Overview:
- Receiver/sink for the pixel stream produced by the CNN activation cores (sigmoid and similar). Each core emits one DATA_WIDTH word per cycle in which its done strobe is high; no backpressure.
- Absorbs that stream into a small FIFO and tags each word with channel position: end of channel, end of frame.
- Re-emits the words on a ready/valid interface toward the frame-buffer writer.
- Reports frame completion and error conditions.

Parameters:
- DATA_WIDTH, 32: word width (IEEE-754 single).
- IMAGE_WIDTH, 256: pixels per row.
- IMAGE_HEIGHT, 256: rows per channel.
- CHANNEL_NUM, 7: channels per frame.
- FIFO_DEPTH, 16: FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle pulse that starts collection of a frame; honoured only in IDLE.
- in_valid  in  1  producer done strobe.
- in_data  in  DATA_WIDTH  producer out_fp.
- out_valid  out  1  output word available.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  output word.
- out_last_pixel  out  1  word is the last pixel of its channel.
- out_last_frame  out  1  word is the last pixel of the last channel.
- frame_done  out  1  one-cycle completion pulse.
- busy  out  1  high in COLLECT and DRAIN.
- overflow  out  1  sticky: an input word was dropped because the FIFO was full.
- err_stray  out  1  sticky: in_valid was seen outside COLLECT.
- ch_idx  out  clog2(CHANNEL_NUM)  current input channel.
- pix_idx  out  clog2(IMAGE_WIDTH*IMAGE_HEIGHT)  current input pixel within the channel.

Behaviour:
- Reset (asynchronous, rst=1): all outputs and counters are 0; FIFO is empty; FSM is in IDLE. Reset applies immediately, including mid-frame; there is no partial flush.
- IMAGE_SIZE = IMAGE_WIDTH*IMAGE_HEIGHT; TOTAL = CHANNEL_NUM*IMAGE_SIZE.
- FSM states:
  - IDLE: arm=1 clears pix_idx, ch_idx, overflow and err_stray, then goes to COLLECT.
  - COLLECT: each in_valid=1 cycle counts as one received pixel. After the TOTAL-th pixel, the next state is DRAIN.
  - DRAIN: when the FIFO is empty and no word is pending on the output, the next state is DONE.
  - DONE: frame_done=1 for exactly that cycle, then IDLE.
- arm in any state other than IDLE is ignored.
- Counting, in COLLECT with in_valid=1:
  - The word is tagged last_pixel = (pix_idx==IMAGE_SIZE-1) and last_frame = last_pixel & (ch_idx==CHANNEL_NUM-1).
  - pix_idx wraps from IMAGE_SIZE-1 to 0, and ch_idx increments on that wrap. After the final pixel both counters read 0.
- FIFO:
  - Entry width is DATA_WIDTH+2 (data plus the two tags).
  - Push on in_valid in COLLECT.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle while full is legal: no drop and no overflow.
- Overflow: push while full with no pop drops the word and sets overflow. The word still counts toward pix_idx/ch_idx so channel alignment is preserved; the output stream is then short. frame_done still fires after the drain.
- Stray input: in_valid in IDLE, DRAIN or DONE is ignored (no push, no count) and sets err_stray.
- Output latency: a word pushed at edge N into an empty FIFO shows out_valid=1 after edge N+1.
- Output hold: while out_valid=1 and out_ready=0, out_data and both tags hold stable.
- Ordering: strict FIFO order. Back-to-back throughput is 1 word/cycle when out_ready=1.
- busy = (state==COLLECT) | (state==DRAIN).

Decomposition:
- Shared package cnn_pkg:
  - DATA_WIDTH default.
  - FSM state encoding: IDLE=0, COLLECT=1, DRAIN=2, DONE=3.
  - clog2 helper function.
  - Tag bit positions (LAST_PIXEL_BIT, LAST_FRAME_BIT).
- Sub-module cnn_sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty; registered read). It is reusable by other CNN stream blocks.
- Counters and FSM live in the top module.

Test Plan:
All scenarios use IMAGE_WIDTH=2, IMAGE_HEIGHT=2, CHANNEL_NUM=2, FIFO_DEPTH=4.
1. Reset check: assert rst mid-cycle -> every output 0 immediately; FSM in IDLE after release.
2. Clean frame: arm, then 8 consecutive in_valid with data 0x3F000000+i, out_ready=1.
   - Outputs are the same 8 values, each 1 cycle after its input.
   - out_last_pixel is high on words 3 and 7; out_last_frame is high on word 7 only.
   - frame_done pulses once; busy falls with it.
3. Overflow: out_ready=0, arm, 5 inputs.
   - 4 words are stored; the 5th is dropped and overflow=1.
   - pix_idx=1, ch_idx=1.
   - Raise out_ready -> the 4 stored words emerge in order.
4. Full with simultaneous pop: fill the FIFO (4 words), then assert out_ready and in_valid in the same cycle -> overflow stays 0 and no word is lost.
5. Stray and re-arm:
   - in_valid in IDLE -> err_stray=1, no output.
   - arm while busy -> ignored.
   - Next arm from IDLE -> err_stray cleared.
6. Reset mid-frame: after 3 inputs, pulse rst -> FIFO empty, counters 0, out_valid=0. A fresh frame then completes normally.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// cnn_pkg : shared types, constants and helpers for the CNN stream blocks
// Rev 1.0
// ============================================================================
package cnn_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    // Tag field sits directly above the data word in every stream entry
    localparam int TAG_WIDTH      = 2;
    localparam int LAST_PIXEL_BIT = 0;
    localparam int LAST_FRAME_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cnn_sync_fifo.sv
`default_nettype none
// ============================================================================
// cnn_sync_fifo : synchronous FIFO with a registered head-of-queue output
// Rev 1.0
// ============================================================================
module cnn_sync_fifo
    import cnn_pkg::*;
#(
    parameter int WIDTH = 34,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    logic w_pop_fire;
    logic w_write;
    logic w_mem_empty;
    logic w_load;

    // r_count covers the memory and the output register, so DEPTH is the
    // total number of words the FIFO can hold.
    assign full        = (r_count == C_FULL);
    assign empty       = (r_count == '0);
    assign w_pop_fire  = pop & r_valid;
    assign w_write     = push & (~full | w_pop_fire);
    assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
    assign w_load      = (~r_valid | w_pop_fire) & ~w_mem_empty;

    assign pop_data = r_data;
    assign valid    = r_valid;

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_data   <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_valid  <= 1'b1;
            end else if (w_pop_fire) begin
                r_valid  <= 1'b0;
            end
            case ({w_write, w_pop_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_stream_collector.sv
`default_nettype none
// ============================================================================
// cnn_stream_collector : buffers an activation-core pixel stream, tags channel
// and frame boundaries, and re-emits it on a ready/valid interface. Rev 1.0
// ============================================================================
module cnn_stream_collector
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int CHANNEL_NUM  = 7,
    parameter int FIFO_DEPTH   = 16,
    localparam int CH_W        = clog2(CHANNEL_NUM),
    localparam int PIX_W       = clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last_pixel,
    output logic                  out_last_frame,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  err_stray,
    output logic [CH_W-1:0]       ch_idx,
    output logic [PIX_W-1:0]      pix_idx
);

    localparam int IMAGE_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int ENTRY_W    = DATA_WIDTH + TAG_WIDTH;
    localparam logic [PIX_W-1:0] C_PIX_LAST = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [CH_W-1:0]  C_CH_LAST  = CH_W'(CHANNEL_NUM - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [PIX_W-1:0] r_pix;
    logic [CH_W-1:0]  r_ch;
    logic             r_overflow;
    logic             r_err_stray;

    logic                 w_collect;
    logic                 w_in_frame;
    logic                 w_stray;
    logic                 w_arm_idle;
    logic                 w_last_pixel;
    logic                 w_last_frame;
    logic                 w_drop;
    logic [TAG_WIDTH-1:0] w_tags;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_pop_data;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;

    assign w_collect    = (r_state == ST_COLLECT);
    assign w_in_frame   = w_collect & in_valid;
    assign w_stray      = in_valid & ~w_collect;
    assign w_arm_idle   = arm & (r_state == ST_IDLE);
    assign w_last_pixel = (r_pix == C_PIX_LAST);
    assign w_last_frame = w_last_pixel & (r_ch == C_CH_LAST);

    always_comb begin
        w_tags                 = '0;
        w_tags[LAST_PIXEL_BIT] = w_last_pixel;
        w_tags[LAST_FRAME_BIT] = w_last_frame;
    end

    assign w_push_data = {w_tags, in_data};

    // A full FIFO still accepts a word when the head is leaving this cycle
    assign w_drop = w_in_frame & w_fifo_full & ~(out_valid & out_ready);

    cnn_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_in_frame),
        .push_data (w_push_data),
        .pop       (out_ready),
        .pop_data  (w_pop_data),
        .valid     (out_valid),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign out_data       = w_pop_data[DATA_WIDTH-1:0];
    assign out_last_pixel = w_pop_data[DATA_WIDTH + LAST_PIXEL_BIT];
    assign out_last_frame = w_pop_data[DATA_WIDTH + LAST_FRAME_BIT];

    always_comb begin
        w_state_next = r_state;
        frame_done   = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm) begin
                    w_state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                busy = 1'b1;
                if (in_valid && w_last_frame) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (w_fifo_empty) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_pix       <= '0;
            r_ch        <= '0;
            r_overflow  <= 1'b0;
            r_err_stray <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Dropped words still advance the counters to keep channel alignment
            if (w_arm_idle) begin
                r_pix <= '0;
                r_ch  <= '0;
            end else if (w_in_frame) begin
                if (w_last_pixel) begin
                    r_pix <= '0;
                    r_ch  <= w_last_frame ? '0 : r_ch + 1'b1;
                end else begin
                    r_pix <= r_pix + 1'b1;
                end
            end
            if (w_arm_idle) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_err_stray <= (w_arm_idle ? 1'b0 : r_err_stray) | w_stray;
        end
    end

    assign overflow  = r_overflow;
    assign err_stray = r_err_stray;
    assign ch_idx    = r_ch;
    assign pix_idx   = r_pix;

endmodule
`default_nettype wire

// File: tb/tb_cnn_stream_collector.sv
`default_nettype none
// ============================================================================
// tb_cnn_stream_collector : directed scoreboard bench, 2x2 image, 2 channels,
// FIFO depth 4. Rev 1.0
// ============================================================================
module tb_cnn_stream_collector;

    localparam int DW  = 32;
    localparam int IW  = 2;
    localparam int IH  = 2;
    localparam int CN  = 2;
    localparam int FD  = 4;
    localparam int ISZ = IW * IH;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          arm       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last_pixel;
    logic          out_last_frame;
    logic          frame_done;
    logic          busy;
    logic          overflow;
    logic          err_stray;
    logic [0:0]    ch_idx;
    logic [1:0]    pix_idx;

    int n_vec = 0;
    int n_err = 0;
    int bpix  = 0;
    int bch   = 0;

    typedef struct packed {
        logic          lf;
        logic          lp;
        logic [DW-1:0] d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cnn_stream_collector #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (IW),
        .IMAGE_HEIGHT (IH),
        .CHANNEL_NUM  (CN),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last_pixel (out_last_pixel),
        .out_last_frame (out_last_frame),
        .frame_done     (frame_done),
        .busy           (busy),
        .overflow       (overflow),
        .err_stray      (err_stray),
        .ch_idx         (ch_idx),
        .pix_idx        (pix_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm  = 1'b0;
        bpix = 0;
        bch  = 0;
    endtask

    // Expected tags come from the bench's own pixel/channel position
    task automatic send(input logic [DW-1:0] d, input bit accept);
        exp_t e;
        e.d  = d;
        e.lp = (bpix == ISZ - 1);
        e.lf = e.lp && (bch == CN - 1);
        if (accept) sb.push_back(e);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        if (bpix == ISZ - 1) begin
            bpix = 0;
            bch  = (bch == CN - 1) ? 0 : bch + 1;
        end else begin
            bpix++;
        end
    endtask

    task automatic drain_wait(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            step();
            k++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!frame_done && k < 60) begin
            step();
            k++;
        end
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd1);
        chk({tag, "_busy_low"}, 64'(busy), 64'd0);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        step();
        chk({tag, "_done_pulse"}, 64'(frame_done), 64'd0);
    endtask

    // Output monitor: head word must match while stalled, popped on handshake
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                chk("out_word", 64'({out_last_frame, out_last_pixel, out_data}), 64'(sb[0]));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        chk("reset_outputs",
            64'({out_valid, out_data, out_last_pixel, out_last_frame, frame_done,
                 busy, overflow, err_stray, ch_idx, pix_idx}), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("idle_after_reset", 64'({busy, frame_done, out_valid}), 64'd0);

        // Clean frame with one-cycle latency and full throughput
        out_ready = 1'b1;
        do_arm();
        chk("armed_busy", 64'(busy), 64'd1);
        send(32'h3F000000, 1'b1);
        chk("latency_edge_n", 64'(out_valid), 64'd0);
        send(32'h3F000001, 1'b1);
        chk("latency_edge_n1", 64'(out_valid), 64'd1);
        for (int i = 2; i < 8; i++) send(32'h3F000000 + DW'(i), 1'b1);
        chk("throughput_backlog", 64'(sb.size()), 64'd2);
        wait_done("clean");

        // Overflow: fifth word dropped while stalled
        out_ready = 1'b0;
        do_arm();
        for (int i = 0; i < 4; i++) send(32'h40000000 + DW'(i), 1'b1);
        chk("ovf_before_full", 64'(overflow), 64'd0);
        send(32'h40000004, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_pix_idx", 64'(pix_idx), 64'd1);
        chk("ovf_ch_idx", 64'(ch_idx), 64'd1);
        out_ready = 1'b1;
        drain_wait("ovf");
        for (int i = 5; i < 8; i++) send(32'h40000000 + DW'(i), 1'b1);
        wait_done("ovf");
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Push into a full FIFO while the head is popped
        out_ready = 1'b0;
        do_arm();
        chk("arm_clears_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) send(32'h41000000 + DW'(i), 1'b1);
        out_ready = 1'b1;
        send(32'h41000004, 1'b1);
        chk("fullpop_no_ovf", 64'(overflow), 64'd0);
        for (int i = 5; i < 8; i++) send(32'h41000000 + DW'(i), 1'b1);
        wait_done("fullpop");
        chk("fullpop_ovf_end", 64'(overflow), 64'd0);

        // Stray input in IDLE, arm while busy, re-arm clears stray flag
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        chk("stray_set", 64'(err_stray), 64'd1);
        chk("stray_no_count", 64'(pix_idx), 64'd0);
        step();
        chk("stray_no_out", 64'(out_valid), 64'd0);
        do_arm();
        chk("stray_cleared", 64'(err_stray), 64'd0);
        send(32'h42000000, 1'b1);
        send(32'h42000001, 1'b1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_busy_pix", 64'(pix_idx), 64'd2);
        chk("arm_busy_state", 64'(busy), 64'd1);
        for (int i = 2; i < 8; i++) send(32'h42000000 + DW'(i), 1'b1);
        wait_done("rearm");

        // Reset in the middle of a frame
        out_ready = 1'b0;
        do_arm();
        for (int i = 0; i < 3; i++) send(32'h43000000 + DW'(i), 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out",
            64'({out_valid, out_data, out_last_pixel, out_last_frame}), 64'd0);
        chk("midrst_counters", 64'({ch_idx, pix_idx}), 64'd0);
        chk("midrst_flags", 64'({busy, overflow, err_stray, frame_done}), 64'd0);
        sb.delete();
        step();
        rst = 1'b0;
        step();
        chk("midrst_fifo_empty", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        do_arm();
        for (int i = 0; i < 8; i++) send(32'h44000000 + DW'(i), 1'b1);
        wait_done("postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
